avmm_csr_slave: RTL and testbench
=================================

# avmm_csr_slave

Avalon-MM slave front end for the sequencer's CSR space. It decodes host reads and writes into per-register one-hot REG_SELECT plus REG_READ/REG_WRITE strobes that drive the read-only shadow and read/write registers. It holds the select and read strobes for the whole read, so shadow contents stay frozen until the read data is muxed and returned. It sits between the host-facing Avalon-MM agent and the register bank.

## Interface
Reset is synchronous and active-low, on RESET_N sampled at posedge CLOCK. All logic is in the CLOCK domain.

Parameters:
- P_DATA_WIDTH, 32: register/data bus width.
- P_ADDR_WIDTH, 4: word address width.
- P_NUM_REGS, 16: implemented registers, 1..2**P_ADDR_WIDTH.

Ports:
- CLOCK  in  1  sole clock.
- RESET_N  in  1  synchronous, active-low reset.
- AVMM_ADDRESS  in  P_ADDR_WIDTH  word address.
- AVMM_READ  in  1  read request.
- AVMM_WRITE  in  1  write request.
- AVMM_WRITEDATA  in  P_DATA_WIDTH  write data.
- AVMM_READDATA  out  P_DATA_WIDTH  registered read data.
- AVMM_WAITREQUEST  out  1  transfer stall.
- REG_SELECT  out  P_NUM_REGS  one-hot register select, registered.
- REG_READ  out  1  read strobe, registered.
- REG_WRITE  out  1  write strobe, registered.
- REG_WRDATA  out  P_DATA_WIDTH  registered copy of write data.
- REG_RDDATA  in  P_NUM_REGS*P_DATA_WIDTH  flattened register outputs; register i is at bits [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- ERR_ADDR  out  1  one-cycle pulse on an illegal access.

## Operation
FSM states: IDLE, RD_HOLD, RD_MUX, RD_DONE, WR_DONE.

Reset values:
- FSM in IDLE.
- REG_SELECT, REG_READ, REG_WRITE, ERR_ADDR = 0.
- AVMM_READDATA, REG_WRDATA = 0.

IDLE:
- AVMM_READ=1: latch address, set REG_SELECT[addr] and REG_READ, go to RD_HOLD.
- AVMM_WRITE=1 and READ=0: set REG_SELECT[addr] and REG_WRITE, latch REG_WRDATA, go to WR_DONE.
- AVMM_READ and AVMM_WRITE both high: handle as a read, ignore the write, pulse ERR_ADDR.

RD_HOLD:
- One cycle for frozen shadow outputs to settle. Go to RD_MUX.

RD_MUX:
- AVMM_READDATA <= selected slice of REG_RDDATA. Go to RD_DONE.

RD_DONE:
- WAITREQUEST low for one cycle.
- Clear REG_SELECT and REG_READ; shadows resume tracking on the next edge.
- Go to IDLE.

WR_DONE:
- WAITREQUEST low for one cycle.
- Clear REG_SELECT and REG_WRITE. Go to IDLE.
- REG_WRITE is therefore exactly one cycle wide.

Address ≥ P_NUM_REGS:
- REG_SELECT stays all-zero and no register is touched.
- Reads return 0; writes are dropped.
- ERR_ADDR pulses in the cycle after acceptance.
- Normal state sequence and latency still apply.

Master deasserts AVMM_READ or AVMM_WRITE mid-transfer (protocol violation):
- Abort to IDLE on the next edge and clear all strobes.
- AVMM_READDATA keeps its last value.

RESET_N low in any state: all registered outputs return to reset values on that edge; the transaction is lost.

## Timing
- AVMM_WAITREQUEST is combinational: `(READ|WRITE) & ~(state==RD_DONE | state==WR_DONE)`. It is low whenever no request is present.
- Read, request at cycle 0:
  - REG_SELECT/REG_READ high in cycles 1–3.
  - Shadow registers hold their cycle-0 sample.
  - AVMM_READDATA valid from cycle 3.
  - WAITREQUEST low in cycle 3; accepted at the end of cycle 3.
  - 4 cycles per read.
- Write, request at cycle 0:
  - REG_SELECT/REG_WRITE high in cycle 1.
  - WAITREQUEST low in cycle 1.
  - 2 cycles per write.
- Back-to-back transfers: IDLE can accept on the cycle after DONE. There are no zero-wait or pipelined transfers.
- AVMM_READDATA holds its value between reads.

## Structure
- Shared package `csr_pkg`:
  - FSM state enum `csr_state_t`.
  - Default width constants.
  - `ERR_READ_VALUE` (= '0).
- No sub-module is required.
- Optional: the read mux as `csr_rd_mux` (parameterised P_NUM_REGS/P_DATA_WIDTH, combinational index select).
- Target size: ~150–250 lines.

## Test plan
- Read reg 3:
  - Stimulus: slice 3 = 0x0000_00A5, READ at cycle 0.
  - Response: REG_SELECT=0x0008 with REG_READ in cycles 1–3; READDATA=0x0000_00A5 with WAITREQUEST=0 in cycle 3.
  - Change the slice in cycle 1: returned data is unaffected.
- Write 0x1234_5678 to reg 7:
  - Response: REG_SELECT=0x0080, REG_WRITE=1 and REG_WRDATA=0x1234_5678 for exactly cycle 1; WAITREQUEST low in cycle 1.
- Read address 15 with P_NUM_REGS=12:
  - Response: REG_SELECT stays 0, READDATA=0 in cycle 3, ERR_ADDR pulses in cycle 1.
- READ and WRITE both high on address 2:
  - Response: read sequence runs, REG_WRITE never asserts, ERR_ADDR pulses once.
- RESET_N low in RD_MUX:
  - Response: next cycle all strobes are 0, READDATA=0, FSM in IDLE.
  - A new read completes normally afterwards.
- Write followed immediately by a read (reg 1, then reg 1):
  - Response: the read returns the written value via a loopback register model.
  - Total time 6 cycles.

Source files
------------

// File: rtl/avmm_csr_slave_pkg.sv
// Shared definitions for the Avalon-MM CSR slave: FSM state encoding,
// default widths and the value returned for reads of unimplemented addresses.
package csr_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 4;
   localparam int unsigned DEF_NUM_REGS   = 16;

   localparam logic [DEF_DATA_WIDTH-1:0] ERR_READ_VALUE = '0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_HOLD = 3'd1,
      RD_MUX  = 3'd2,
      RD_DONE = 3'd3,
      WR_DONE = 3'd4
   } csr_state_t;

endpackage

// File: rtl/avmm_csr_slave_rd_mux.sv
// Read-data multiplexer: picks one register slice out of the flattened
// register output bus by word index. Out-of-range indices yield zero.
module csr_rd_mux #(
   parameter int unsigned P_NUM_REGS   = 16,
   parameter int unsigned P_DATA_WIDTH = 32,
   parameter int unsigned P_SEL_WIDTH  = 4
) (
   input  logic [P_NUM_REGS*P_DATA_WIDTH-1:0] rd_bus,
   input  logic [P_SEL_WIDTH-1:0]             sel,
   output logic [P_DATA_WIDTH-1:0]            rd_data
);

   // Combinational index select over the implemented registers
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < P_NUM_REGS; i++) begin
         if (32'(sel) == i) begin
            rd_data = rd_bus[i*P_DATA_WIDTH +: P_DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/avmm_csr_slave.sv
// Avalon-MM slave front end for the sequencer CSR space. Turns host reads and
// writes into a registered one-hot register select plus read/write strobes.
// The select and read strobe are held for the whole read so that shadow
// registers stay frozen until the data has been muxed and returned.
module avmm_csr_slave
   import csr_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned P_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned P_NUM_REGS   = DEF_NUM_REGS
) (
   input  logic                               CLOCK,
   input  logic                               RESET_N,
   input  logic [P_ADDR_WIDTH-1:0]            AVMM_ADDRESS,
   input  logic                               AVMM_READ,
   input  logic                               AVMM_WRITE,
   input  logic [P_DATA_WIDTH-1:0]            AVMM_WRITEDATA,
   output logic [P_DATA_WIDTH-1:0]            AVMM_READDATA,
   output logic                               AVMM_WAITREQUEST,
   output logic [P_NUM_REGS-1:0]              REG_SELECT,
   output logic                               REG_READ,
   output logic                               REG_WRITE,
   output logic [P_DATA_WIDTH-1:0]            REG_WRDATA,
   input  logic [P_NUM_REGS*P_DATA_WIDTH-1:0] REG_RDDATA,
   output logic                               ERR_ADDR
);

   localparam logic [P_DATA_WIDTH-1:0] L_ERR_VALUE = P_DATA_WIDTH'(ERR_READ_VALUE);

   csr_state_t               state;
   logic [P_ADDR_WIDTH-1:0]  addr_q;
   logic                     addr_ok_q;
   logic                     addr_ok;
   logic [P_NUM_REGS-1:0]    sel_dec;
   logic [P_DATA_WIDTH-1:0]  mux_data;

   // Decode the incoming word address into a one-hot select; unimplemented
   // addresses decode to all-zero so no register is ever touched by them
   always_comb begin
      sel_dec = '0;
      addr_ok = 1'b0;
      for (int unsigned i = 0; i < P_NUM_REGS; i++) begin
         if (32'(AVMM_ADDRESS) == i) begin
            sel_dec[i] = 1'b1;
            addr_ok    = 1'b1;
         end
      end
   end

   // Stall every request until the FSM reaches a completion state
   always_comb begin
      AVMM_WAITREQUEST = (AVMM_READ | AVMM_WRITE) &
                         ~((state == RD_DONE) | (state == WR_DONE));
   end

   csr_rd_mux #(
      .P_NUM_REGS   (P_NUM_REGS),
      .P_DATA_WIDTH (P_DATA_WIDTH),
      .P_SEL_WIDTH  (P_ADDR_WIDTH)
   ) u_rd_mux (
      .rd_bus  (REG_RDDATA),
      .sel     (addr_q),
      .rd_data (mux_data)
   );

   // Transfer sequencer: accept, hold strobes through the read, return data
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state         <= IDLE;
         addr_q        <= '0;
         addr_ok_q     <= 1'b0;
         REG_SELECT    <= '0;
         REG_READ      <= 1'b0;
         REG_WRITE     <= 1'b0;
         REG_WRDATA    <= '0;
         AVMM_READDATA <= '0;
         ERR_ADDR      <= 1'b0;
      end else begin
         ERR_ADDR <= 1'b0;
         unique case (state)
            IDLE: begin
               // A simultaneous read and write is served as a read and flagged
               if (AVMM_READ) begin
                  addr_q     <= AVMM_ADDRESS;
                  addr_ok_q  <= addr_ok;
                  REG_SELECT <= sel_dec;
                  REG_READ   <= addr_ok;
                  ERR_ADDR   <= ~addr_ok | AVMM_WRITE;
                  state      <= RD_HOLD;
               end else if (AVMM_WRITE) begin
                  addr_q     <= AVMM_ADDRESS;
                  addr_ok_q  <= addr_ok;
                  REG_SELECT <= sel_dec;
                  REG_WRITE  <= addr_ok;
                  if (addr_ok) begin
                     REG_WRDATA <= AVMM_WRITEDATA;
                  end
                  ERR_ADDR   <= ~addr_ok;
                  state      <= WR_DONE;
               end
            end
            RD_HOLD: begin
               if (!AVMM_READ) begin
                  REG_SELECT <= '0;
                  REG_READ   <= 1'b0;
                  state      <= IDLE;
               end else begin
                  state <= RD_MUX;
               end
            end
            RD_MUX: begin
               if (!AVMM_READ) begin
                  REG_SELECT <= '0;
                  REG_READ   <= 1'b0;
                  state      <= IDLE;
               end else begin
                  AVMM_READDATA <= addr_ok_q ? mux_data : L_ERR_VALUE;
                  state         <= RD_DONE;
               end
            end
            RD_DONE: begin
               REG_SELECT <= '0;
               REG_READ   <= 1'b0;
               state      <= IDLE;
            end
            WR_DONE: begin
               REG_SELECT <= '0;
               REG_WRITE  <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               REG_SELECT <= '0;
               REG_READ   <= 1'b0;
               REG_WRITE  <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avmm_csr_slave.sv
// Directed bench for avmm_csr_slave with 12 implemented registers behind a
// small register bank model: writable live registers plus shadow copies that
// freeze while their select and the read strobe are held.
module tb_avmm_csr_slave;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned NR = 12;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   address = '0;
   logic            read = 1'b0;
   logic            write = 1'b0;
   logic [DW-1:0]   writedata = '0;
   logic [DW-1:0]   readdata;
   logic            waitrequest;
   logic [NR-1:0]   reg_select;
   logic            reg_read;
   logic            reg_write;
   logic [DW-1:0]   reg_wrdata;
   logic [NR*DW-1:0] reg_rddata;
   logic            err_addr;

   logic            poke_en = 1'b0;
   int unsigned     poke_idx = 0;
   logic [DW-1:0]   poke_val = '0;
   logic [DW-1:0]   live   [NR] = '{default: '0};
   logic [DW-1:0]   shadow [NR] = '{default: '0};

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   avmm_csr_slave #(
      .P_DATA_WIDTH (DW),
      .P_ADDR_WIDTH (AW),
      .P_NUM_REGS   (NR)
   ) dut (
      .CLOCK            (clk),
      .RESET_N          (rst_n),
      .AVMM_ADDRESS     (address),
      .AVMM_READ        (read),
      .AVMM_WRITE       (write),
      .AVMM_WRITEDATA   (writedata),
      .AVMM_READDATA    (readdata),
      .AVMM_WAITREQUEST (waitrequest),
      .REG_SELECT       (reg_select),
      .REG_READ         (reg_read),
      .REG_WRITE        (reg_write),
      .REG_WRDATA       (reg_wrdata),
      .REG_RDDATA       (reg_rddata),
      .ERR_ADDR         (err_addr)
   );

   // Register bank model: host-side pokes and DUT writes update live values,
   // shadows follow live values except while selected for a read
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) begin
         if (poke_en && poke_idx == i) begin
            live[i] <= poke_val;
         end else if (reg_write && reg_select[i]) begin
            live[i] <= reg_wrdata;
         end
         if (!(reg_read && reg_select[i])) begin
            shadow[i] <= live[i];
         end
      end
   end

   // Flatten shadow outputs onto the register read bus
   always_comb begin
      reg_rddata = '0;
      for (int i = 0; i < NR; i++) begin
         reg_rddata[i*DW +: DW] = shadow[i];
      end
   end

   task automatic next_cycle();
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic poke(input int unsigned idx, input logic [DW-1:0] val);
      next_cycle();
      poke_idx = idx;
      poke_val = val;
      poke_en  = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) next_cycle();
      #1;
      checks++;
      if (reg_select !== '0 || reg_read !== 1'b0 || reg_write !== 1'b0 || err_addr !== 1'b0) begin
         failures++;
         $display("FAIL reset_strobes: sel=%h rd=%b wr=%b err=%b, required all 0", reg_select, reg_read, reg_write, err_addr);
      end
      checks++;
      if (readdata !== '0 || reg_wrdata !== '0) begin
         failures++;
         $display("FAIL reset_data: readdata=%h wrdata=%h, required 0/0", readdata, reg_wrdata);
      end
      checks++;
      if (waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL reset_waitreq: got %b, required 0", waitrequest);
      end
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_read_reg3();
      // cycle 0
      next_cycle();
      address = 4'd3;
      read    = 1'b1;
      #1;
      checks++;
      if (waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rd3_wait_c0: got %b, required 1", waitrequest);
      end
      // cycle 1: strobes up, live value changes behind the frozen shadow
      next_cycle();
      poke_idx = 3;
      poke_val = 32'h0000_00FF;
      poke_en  = 1'b1;
      #1;
      checks++;
      if (reg_select !== 12'h008 || reg_read !== 1'b1 || reg_write !== 1'b0 || err_addr !== 1'b0) begin
         failures++;
         $display("FAIL rd3_c1: sel=%h rd=%b wr=%b err=%b, required 008/1/0/0", reg_select, reg_read, reg_write, err_addr);
      end
      checks++;
      if (waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rd3_wait_c1: got %b, required 1", waitrequest);
      end
      // cycle 2
      next_cycle();
      #1;
      checks++;
      if (reg_select !== 12'h008 || reg_read !== 1'b1 || waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rd3_c2: sel=%h rd=%b wait=%b, required 008/1/1", reg_select, reg_read, waitrequest);
      end
      // cycle 3: data returned, transfer accepted
      next_cycle();
      #1;
      checks++;
      if (readdata !== 32'h0000_00A5 || waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL rd3_c3: readdata=%h wait=%b, required 000000a5/0", readdata, waitrequest);
      end
      checks++;
      if (reg_select !== 12'h008 || reg_read !== 1'b1) begin
         failures++;
         $display("FAIL rd3_hold_c3: sel=%h rd=%b, required 008/1", reg_select, reg_read);
      end
      // cycle 4: strobes released, data held
      next_cycle();
      read = 1'b0;
      #1;
      checks++;
      if (reg_select !== '0 || reg_read !== 1'b0 || waitrequest !== 1'b0 || readdata !== 32'h0000_00A5) begin
         failures++;
         $display("FAIL rd3_c4: sel=%h rd=%b wait=%b readdata=%h, required 000/0/0/000000a5", reg_select, reg_read, waitrequest, readdata);
      end
   endtask

   task automatic test_write_reg7();
      next_cycle();
      address   = 4'd7;
      write     = 1'b1;
      writedata = 32'h1234_5678;
      #1;
      checks++;
      if (waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL wr7_wait_c0: got %b, required 1", waitrequest);
      end
      next_cycle();
      #1;
      checks++;
      if (reg_select !== 12'h080 || reg_write !== 1'b1 || reg_read !== 1'b0 || reg_wrdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL wr7_c1: sel=%h wr=%b rd=%b wrdata=%h, required 080/1/0/12345678", reg_select, reg_write, reg_read, reg_wrdata);
      end
      checks++;
      if (waitrequest !== 1'b0 || err_addr !== 1'b0) begin
         failures++;
         $display("FAIL wr7_wait_c1: wait=%b err=%b, required 0/0", waitrequest, err_addr);
      end
      next_cycle();
      write = 1'b0;
      #1;
      checks++;
      if (reg_write !== 1'b0 || reg_select !== '0) begin
         failures++;
         $display("FAIL wr7_c2: wr=%b sel=%h, required 0/000", reg_write, reg_select);
      end
   endtask

   task automatic test_illegal_read();
      next_cycle();
      address = 4'd15;
      read    = 1'b1;
      next_cycle();
      #1;
      checks++;
      if (reg_select !== '0 || err_addr !== 1'b1 || waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL ill_rd_c1: sel=%h err=%b wait=%b, required 000/1/1", reg_select, err_addr, waitrequest);
      end
      next_cycle();
      #1;
      checks++;
      if (err_addr !== 1'b0 || reg_select !== '0) begin
         failures++;
         $display("FAIL ill_rd_c2: err=%b sel=%h, required 0/000", err_addr, reg_select);
      end
      next_cycle();
      #1;
      checks++;
      if (readdata !== '0 || waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL ill_rd_c3: readdata=%h wait=%b, required 00000000/0", readdata, waitrequest);
      end
      next_cycle();
      read = 1'b0;
   endtask

   task automatic test_illegal_write();
      next_cycle();
      address   = 4'd13;
      write     = 1'b1;
      writedata = 32'hDEAD_BEEF;
      next_cycle();
      #1;
      checks++;
      if (reg_select !== '0 || reg_write !== 1'b0 || err_addr !== 1'b1 || waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL ill_wr_c1: sel=%h wr=%b err=%b wait=%b, required 000/0/1/0", reg_select, reg_write, err_addr, waitrequest);
      end
      next_cycle();
      write = 1'b0;
      #1;
      checks++;
      if (err_addr !== 1'b0) begin
         failures++;
         $display("FAIL ill_wr_c2: err=%b, required 0", err_addr);
      end
   endtask

   task automatic test_read_write_both();
      int err_cnt = 0;
      int wr_cnt  = 0;
      next_cycle();
      address   = 4'd2;
      read      = 1'b1;
      write     = 1'b1;
      writedata = 32'hFFFF_FFFF;
      next_cycle();
      #1;
      checks++;
      if (reg_select !== 12'h004 || reg_read !== 1'b1 || reg_write !== 1'b0 || err_addr !== 1'b1) begin
         failures++;
         $display("FAIL both_c1: sel=%h rd=%b wr=%b err=%b, required 004/1/0/1", reg_select, reg_read, reg_write, err_addr);
      end
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) begin
            next_cycle();
            if (c == 4) begin
               read  = 1'b0;
               write = 1'b0;
            end
            #1;
         end
         if (err_addr === 1'b1) err_cnt++;
         if (reg_write === 1'b1) wr_cnt++;
         if (c == 3) begin
            checks++;
            if (readdata !== 32'h0BAD_F00D || waitrequest !== 1'b0) begin
               failures++;
               $display("FAIL both_c3: readdata=%h wait=%b, required 0badf00d/0", readdata, waitrequest);
            end
         end
      end
      checks++;
      if (err_cnt != 1 || wr_cnt != 0) begin
         failures++;
         $display("FAIL both_pulses: err_cycles=%0d wr_cycles=%0d, required 1/0", err_cnt, wr_cnt);
      end
   endtask

   task automatic test_abort();
      next_cycle();
      address = 4'd3;
      read    = 1'b1;
      next_cycle();
      read = 1'b0;
      next_cycle();
      #1;
      checks++;
      if (reg_select !== '0 || reg_read !== 1'b0 || waitrequest !== 1'b0 || readdata !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL abort: sel=%h rd=%b wait=%b readdata=%h, required 000/0/0/0badf00d", reg_select, reg_read, waitrequest, readdata);
      end
   endtask

   task automatic test_reset_mid_read();
      next_cycle();
      address = 4'd3;
      read    = 1'b1;
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      #1;
      checks++;
      if (reg_select !== '0 || reg_read !== 1'b0 || err_addr !== 1'b0 || readdata !== '0 || reg_wrdata !== '0) begin
         failures++;
         $display("FAIL rst_mid: sel=%h rd=%b err=%b readdata=%h wrdata=%h, required all 0", reg_select, reg_read, err_addr, readdata, reg_wrdata);
      end
      read  = 1'b0;
      rst_n = 1'b1;
      // fresh read of reg 5 with normal timing
      next_cycle();
      address = 4'd5;
      read    = 1'b1;
      next_cycle();
      #1;
      checks++;
      if (reg_select !== 12'h020 || reg_read !== 1'b1) begin
         failures++;
         $display("FAIL rst_new_c1: sel=%h rd=%b, required 020/1", reg_select, reg_read);
      end
      next_cycle();
      #1;
      checks++;
      if (waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rst_new_c2: wait=%b, required 1", waitrequest);
      end
      next_cycle();
      #1;
      checks++;
      if (readdata !== 32'h5555_AAAA || waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL rst_new_c3: readdata=%h wait=%b, required 5555aaaa/0", readdata, waitrequest);
      end
      next_cycle();
      read = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cyc;
      next_cycle();
      address   = 4'd1;
      write     = 1'b1;
      writedata = 32'hCAFE_0001;
      next_cycle();
      #1;
      checks++;
      if (reg_write !== 1'b1 || reg_select !== 12'h002 || waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL b2b_wr_c1: wr=%b sel=%h wait=%b, required 1/002/0", reg_write, reg_select, waitrequest);
      end
      next_cycle();
      write = 1'b0;
      read  = 1'b1;
      #1;
      checks++;
      if (reg_write !== 1'b0 || waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL b2b_rd_c2: wr=%b wait=%b, required 0/1", reg_write, waitrequest);
      end
      next_cycle();
      cyc = 3;
      #1;
      checks++;
      if (reg_select !== 12'h002 || reg_read !== 1'b1) begin
         failures++;
         $display("FAIL b2b_rd_c3: sel=%h rd=%b, required 002/1", reg_select, reg_read);
      end
      while (waitrequest === 1'b1 && cyc < 12) begin
         next_cycle();
         cyc++;
         #1;
      end
      checks++;
      if (cyc + 1 != 6) begin
         failures++;
         $display("FAIL b2b_latency: total cycles=%0d, required 6", cyc + 1);
      end
      checks++;
      if (readdata !== 32'hCAFE_0001) begin
         failures++;
         $display("FAIL b2b_data: readdata=%h, required cafe0001", readdata);
      end
      next_cycle();
      read = 1'b0;
   endtask

   initial begin
      test_reset();
      poke(3, 32'h0000_00A5);
      poke(2, 32'h0BAD_F00D);
      poke(5, 32'h5555_AAAA);
      repeat (2) next_cycle();
      test_read_reg3();
      test_write_reg7();
      test_illegal_read();
      test_illegal_write();
      test_read_write_both();
      test_abort();
      test_reset_mid_read();
      test_back_to_back();
      repeat (2) next_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
